lsh_rom_reader: RTL

Burst read controller that drives the LSH table ROM port (`me`/`address`/`q`, one-cycle registered read latency, output held while `me` is low) and turns ROM words into a valid/ready stream for the LSH hash/compare datapath. A command supplies a base address and word count. The block issues sequential ROM reads under credit control and buffers returned words in a small FIFO, so downstream backpressure never loses data.

---
 rtl/lsh_rom_reader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/lsh_rom_reader.sv
// lsh_rom_reader: burst reader from the LSH table ROM into a valid/ready stream.
// A command (base, count) is range checked first. Sequential reads are then
// issued only while a credit reserves FIFO space for every word not yet popped,
// so a stalled consumer never causes a returned ROM word to be dropped.
//
// Handshakes: a command transfers on a rising edge where cmd_valid && cmd_ready;
// a stream word transfers on a rising edge where out_valid && out_ready.
// Once raised, out_valid holds with out_data/out_last stable until that transfer.
`timescale 1ns/1ps
module lsh_rom_reader #(
   parameter int ADDR_W     = 22,
   parameter int DATA_W     = 80,
   parameter int ROM_DEPTH  = 4096000,
   parameter int CNT_W      = 16,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic [CNT_W-1:0]  cmd_count,
   output logic              rom_me,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_q,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              done,
   output logic              err,
   output logic [1:0]        fsm_state
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] next_addr;
   logic [CNT_W-1:0]  remaining;
   logic              inflight;       // a read was issued last cycle; its word is on rom_q now
   logic              inflight_last;  // that read was the final word of the command
   logic              err_r;

   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic              fifo_last [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [OW-1:0]     occ;

   logic              pop;
   logic              push;
   logic              issue;
   logic              drained;
   logic              range_bad;
   logic [OW:0]       used;
   logic [OW:0]       limit;
   logic [ADDR_W:0]   end_addr;

   // Credit, range check and drain detection. A read issued now lands in the
   // FIFO one cycle later, so it is allowed only if occupancy plus the word
   // already in flight leaves room, counting a pop happening this cycle.
   always_comb begin
      cmd_ready = (state == IDLE);
      out_valid = (occ != '0);
      pop       = out_valid && out_ready;
      push      = inflight;
      used      = (OW+1)'(occ) + (OW+1)'(inflight);
      limit     = (OW+1)'(FIFO_DEPTH) + (OW+1)'(pop);
      issue     = (state == READ) && (remaining != '0) && (used < limit);
      drained   = !inflight && (occ == OW'(pop));
      end_addr  = (ADDR_W+1)'(cmd_base) + (ADDR_W+1)'(cmd_count);
      range_bad = end_addr > (ADDR_W+1)'(ROM_DEPTH);
   end

   assign rom_me    = issue;
   assign rom_addr  = next_addr;
   assign out_data  = fifo_data[rd_ptr];
   assign out_last  = out_valid && fifo_last[rd_ptr];
   assign done      = (state == DONE);
   assign err       = err_r;
   assign fsm_state = state;

   // Command FSM: accept/range check, sequential issue, drain, done pulse.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state         <= IDLE;
         next_addr     <= '0;
         remaining     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         err_r         <= 1'b0;
      end else begin
         inflight      <= issue;
         inflight_last <= issue && (remaining == CNT_W'(1));
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  next_addr <= cmd_base;
                  remaining <= cmd_count;
                  if (cmd_count == '0) begin
                     state <= DONE;
                  end else if (range_bad) begin
                     err_r <= 1'b1;
                     state <= DONE;
                  end else begin
                     err_r <= 1'b0;
                     state <= READ;
                  end
               end
            end
            READ: begin
               if (issue) begin
                  next_addr <= next_addr + ADDR_W'(1);
                  remaining <= remaining - CNT_W'(1);
                  if (remaining == CNT_W'(1)) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (drained) begin
                  state <= DONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Output FIFO: captures rom_q the cycle after each issue, head drives the stream.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data[i] <= '0;
            fifo_last[i] <= 1'b0;
         end
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= rom_q;
            fifo_last[wr_ptr] <= inflight_last;
            wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         end
         occ <= occ + OW'(push) - OW'(pop);
      end
   end

   // The credit scheme must make a push into a full FIFO impossible.
   push_when_full: assert property (@(posedge clock) disable iff (!reset_n)
      !(push && (occ == OW'(FIFO_DEPTH))));

endmodule
